// File: rtl/hpdcache_wbuf_mem_adapter_pkg.sv
// Types and helpers shared by the write-buffer to memory write adapter.
// Memory interface structs are sized for the default 64-bit memory data path.
package hpdcache_wbuf_mem_adapter_pkg;

    localparam int unsigned PA_WIDTH       = 40;
    localparam int unsigned MEM_ID_WIDTH   = 8;
    localparam int unsigned MEM_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        MEM_READ   = 2'd0,
        MEM_WRITE  = 2'd1,
        MEM_ATOMIC = 2'd2
    } mem_command_e;

    typedef enum logic [3:0] {
        ATOMIC_ADD  = 4'd0,
        ATOMIC_CLR  = 4'd1,
        ATOMIC_SET  = 4'd2,
        ATOMIC_EOR  = 4'd3,
        ATOMIC_SMAX = 4'd4,
        ATOMIC_SMIN = 4'd5,
        ATOMIC_UMAX = 4'd6,
        ATOMIC_UMIN = 4'd7,
        ATOMIC_SWAP = 4'd8
    } mem_atomic_e;

    typedef enum logic [1:0] {
        RESP_OK     = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } mem_error_e;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_BURST = 1'b1
    } ser_state_e;

    typedef struct packed {
        logic [PA_WIDTH-1:0]     addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [MEM_ID_WIDTH-1:0] id;
        mem_command_e            command;
        mem_atomic_e             atomic;
        logic                    cacheable;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0]   data;
        logic [MEM_DATA_WIDTH/8-1:0] be;
        logic                        last;
    } mem_req_w_t;

    typedef struct packed {
        mem_error_e              error;
        logic [MEM_ID_WIDTH-1:0] id;
    } mem_resp_w_t;

    function automatic logic [2:0] get_hpdcache_mem_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

    // Ratio of two power-of-2 widths, clamped to 1 when num <= den.
    function automatic int unsigned wbuf_mem_ratio_f(input int unsigned num, input int unsigned den);
        return (num > den) ? num / den : 32'd1;
    endfunction

endpackage

// File: rtl/hpdcache_wbuf_data_serializer.sv
// Splits one wide write-buffer word into DN memory beats, low slice first.
// Accepts the next word on the last beat's handshake so bursts run back to back.
module hpdcache_wbuf_data_serializer
    import hpdcache_wbuf_mem_adapter_pkg::*;
#(
    parameter int unsigned WbufDataWidth = 128,
    parameter int unsigned MemDataWidth  = 64,
    localparam int unsigned DN    = WbufDataWidth / MemDataWidth,
    localparam int unsigned BeatW = $clog2(DN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WbufDataWidth-1:0]  in_data,
    input  logic [WbufDataWidth/8-1:0] in_be,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MemDataWidth-1:0]   out_data,
    output logic [MemDataWidth/8-1:0] out_be,
    output logic                      out_last,
    output logic                      idle
);

    ser_state_e state_q, state_d;
    logic [DN-1:0][MemDataWidth-1:0]   data_q;
    logic [DN-1:0][MemDataWidth/8-1:0] be_q;
    logic [BeatW-1:0] beat_q;
    logic last_beat, capture;

    assign last_beat = (beat_q == BeatW'(DN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                beat_q <= '0;
            end else if (out_valid && out_ready && !last_beat) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            data_q <= in_data;
            be_q   <= in_be;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE:  if (in_valid) state_d = SER_BURST;
            SER_BURST: if (out_ready && last_beat && !in_valid) state_d = SER_IDLE;
            default:   state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            SER_IDLE:  in_ready = 1'b1;
            SER_BURST: begin
                out_valid = 1'b1;
                in_ready  = out_ready & last_beat;
            end
            default: ;
        endcase
        capture = in_valid & in_ready;
    end

    assign out_data = data_q[beat_q];
    assign out_be   = be_q[beat_q];
    assign out_last = last_beat;
    assign idle     = (state_q == SER_IDLE);

endmodule

// File: rtl/hpdcache_wbuf_mem_adapter.sv
// Bridges the write-buffer send channels to the memory write channels for any
// power-of-2 width ratio, and tracks which write ids are still awaiting an ack.
module hpdcache_wbuf_mem_adapter
    import hpdcache_wbuf_mem_adapter_pkg::*;
#(
    parameter int unsigned WbufDataWidth  = 128,
    parameter int unsigned MemDataWidth   = 64,
    parameter int unsigned MemIdWidth     = 8,
    parameter int unsigned WbufIdWidth    = 3,
    parameter int unsigned MaxOutstanding = 8,
    parameter type hpdcache_mem_req_t    = mem_req_t,
    parameter type hpdcache_mem_req_w_t  = mem_req_w_t,
    parameter type hpdcache_mem_resp_w_t = mem_resp_w_t,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       send_meta_valid_i,
    output logic                       send_meta_ready_o,
    input  logic [PA_WIDTH-1:0]        send_addr_i,
    input  logic [WbufIdWidth-1:0]     send_id_i,
    input  logic                       send_uc_i,
    input  logic                       send_data_valid_i,
    output logic                       send_data_ready_o,
    input  logic [PA_WIDTH-1:0]        send_data_tag_i,
    input  logic [WbufDataWidth-1:0]   send_data_i,
    input  logic [WbufDataWidth/8-1:0] send_be_i,
    input  logic                       mem_req_write_ready_i,
    output logic                       mem_req_write_valid_o,
    output hpdcache_mem_req_t          mem_req_write_o,
    input  logic                       mem_req_write_data_ready_i,
    output logic                       mem_req_write_data_valid_o,
    output hpdcache_mem_req_w_t        mem_req_write_data_o,
    output logic                       mem_resp_write_ready_o,
    input  logic                       mem_resp_write_valid_i,
    input  hpdcache_mem_resp_w_t       mem_resp_write_i,
    output logic                       ack_o,
    output logic [WbufIdWidth-1:0]     ack_id_o,
    output logic                       ack_error_o,
    output logic [CntWidth-1:0]        outstanding_o,
    output logic                       idle_o,
    output logic                       spurious_ack_o
);

    localparam int unsigned UP = wbuf_mem_ratio_f(MemDataWidth, WbufDataWidth);
    localparam int unsigned DN = wbuf_mem_ratio_f(WbufDataWidth, MemDataWidth);

    if ((WbufDataWidth & (WbufDataWidth - 1)) != 0 || (MemDataWidth & (MemDataWidth - 1)) != 0) begin : g_bad_width
        $error("data widths must be powers of 2");
    end
    if (MemIdWidth < WbufIdWidth) begin : g_bad_id
        $error("MemIdWidth must be >= WbufIdWidth");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > (2 ** WbufIdWidth)) begin : g_bad_max
        $error("MaxOutstanding must be in 1..2**WbufIdWidth");
    end

    logic [2**WbufIdWidth-1:0] pending_q, pending_d;
    logic [CntWidth-1:0]       count_q;
    logic [WbufIdWidth-1:0]    resp_id;
    logic gate, meta_hs, resp_hit, spurious_q, ser_idle;
    logic unused_bits;

    assign unused_bits = ^{send_data_tag_i, mem_resp_write_i.id};

    // Reset also blocks handshakes so nothing is accepted while state is being cleared.
    assign gate     = ~rst_i & ~pending_q[send_id_i] & (count_q < CntWidth'(MaxOutstanding));
    assign meta_hs  = mem_req_write_valid_o & mem_req_write_ready_i;
    assign resp_id  = mem_resp_write_i.id[WbufIdWidth-1:0];
    assign resp_hit = mem_resp_write_valid_i & pending_q[resp_id];

    assign mem_req_write_valid_o = send_meta_valid_i & gate;
    assign send_meta_ready_o     = mem_req_write_ready_i & gate;

    always_comb begin
        mem_req_write_o           = '0;
        mem_req_write_o.addr      = send_addr_i;
        mem_req_write_o.len       = 8'(DN - 1);
        mem_req_write_o.size      = get_hpdcache_mem_size(WbufDataWidth / 8);
        mem_req_write_o.id        = MemIdWidth'(send_id_i);
        mem_req_write_o.command   = MEM_WRITE;
        mem_req_write_o.atomic    = ATOMIC_ADD;
        mem_req_write_o.cacheable = ~send_uc_i;
    end

    always_comb begin
        pending_d = pending_q;
        if (resp_hit) pending_d[resp_id] = 1'b0;
        if (meta_hs)  pending_d[send_id_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_q + CntWidth'(meta_hs) - CntWidth'(resp_hit);
            spurious_q <= mem_resp_write_valid_i & ~pending_q[resp_id];
        end
    end

    assign mem_resp_write_ready_o = 1'b1;
    assign ack_o          = mem_resp_write_valid_i;
    assign ack_id_o       = resp_id;
    assign ack_error_o    = (mem_resp_write_i.error != RESP_OK);
    assign outstanding_o  = count_q;
    assign spurious_ack_o = spurious_q;
    assign idle_o         = (count_q == '0) & ser_idle;

    if (DN > 1) begin : g_down
        logic ser_in_ready, ser_out_valid, ser_out_last;
        logic [MemDataWidth-1:0]   ser_out_data;
        logic [MemDataWidth/8-1:0] ser_out_be;

        hpdcache_wbuf_data_serializer #(
            .WbufDataWidth(WbufDataWidth),
            .MemDataWidth (MemDataWidth)
        ) i_serializer (
            .clk      (clk_i),
            .rst      (rst_i),
            .in_valid (send_data_valid_i & ~rst_i),
            .in_ready (ser_in_ready),
            .in_data  (send_data_i),
            .in_be    (send_be_i),
            .out_valid(ser_out_valid),
            .out_ready(mem_req_write_data_ready_i),
            .out_data (ser_out_data),
            .out_be   (ser_out_be),
            .out_last (ser_out_last),
            .idle     (ser_idle)
        );

        assign send_data_ready_o          = ser_in_ready & ~rst_i;
        assign mem_req_write_data_valid_o = ser_out_valid & ~rst_i;

        always_comb begin
            mem_req_write_data_o      = '0;
            mem_req_write_data_o.data = ser_out_data;
            mem_req_write_data_o.be   = ser_out_be;
            mem_req_write_data_o.last = ser_out_last;
        end
    end else begin : g_up
        localparam int unsigned LaneBits = (UP > 1) ? $clog2(UP) : 1;
        logic [LaneBits-1:0] lane;
        logic [UP-1:0][WbufDataWidth/8-1:0] be_lanes;

        // The low tag bits name the word's lane inside the wide memory beat.
        assign lane = (UP > 1) ? send_data_tag_i[LaneBits-1:0] : '0;

        always_comb begin
            be_lanes = '0;
            for (int l = 0; l < UP; l++) begin
                if (lane == LaneBits'(l)) be_lanes[l] = send_be_i;
            end
        end

        assign ser_idle                   = 1'b1;
        assign send_data_ready_o          = mem_req_write_data_ready_i & ~rst_i;
        assign mem_req_write_data_valid_o = send_data_valid_i & ~rst_i;

        always_comb begin
            mem_req_write_data_o      = '0;
            mem_req_write_data_o.data = {UP{send_data_i}};
            mem_req_write_data_o.be   = be_lanes;
            mem_req_write_data_o.last = 1'b1;
        end
    end

endmodule

// File: tb/tb_hpdcache_wbuf_mem_adapter.sv
// Bench for the wbuf/mem write adapter: DN=2 (a), UP=4 (b) and DN=4 (c) instances,
// directed corner sequences plus a randomized run against a queue/array model.
module tb_hpdcache_wbuf_mem_adapter;
    import hpdcache_wbuf_mem_adapter_pkg::*;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  be;
        logic         last;
    } req_w256_t;

    typedef struct packed {
        logic [39:0] tag;
        logic [63:0] data;
        logic [7:0]  be;
        logic        mready;
        logic        dvalid;
        logic [31:0] exp_be;
        logic        exp_valid;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  be;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance a: Wbuf 128 / Mem 64, MaxOutstanding 2
    logic a_mv, a_mr, a_uc, a_dv, a_dr, a_qr, a_qv, a_wr, a_wv, a_rr, a_rv, a_ack, a_aerr, a_idle, a_spur;
    logic [39:0] a_addr, a_tag;
    logic [2:0] a_id, a_aid;
    logic [127:0] a_data;
    logic [15:0] a_be;
    logic [1:0] a_out;
    mem_req_t a_req;
    mem_req_w_t a_w;
    mem_resp_w_t a_resp;

    // instance b: Wbuf 64 / Mem 256
    logic b_dv, b_dr, b_wr, b_wv, b_mr, b_qv, b_rr, b_ack, b_aerr, b_idle, b_spur;
    logic [39:0] b_tag;
    logic [63:0] b_data;
    logic [7:0] b_be;
    logic [2:0] b_aid;
    logic [3:0] b_out;
    mem_req_t b_req;
    req_w256_t b_w;

    // instance c: Wbuf 256 / Mem 64, MaxOutstanding 8
    logic c_mv, c_mr, c_uc, c_dv, c_dr, c_qr, c_qv, c_wr, c_wv, c_rr, c_rv, c_ack, c_aerr, c_idle, c_spur;
    logic [39:0] c_addr, c_tag;
    logic [2:0] c_id, c_aid;
    logic [255:0] c_data;
    logic [31:0] c_be;
    logic [3:0] c_out;
    mem_req_t c_req;
    mem_req_w_t c_w;
    mem_resp_w_t c_resp;

    hpdcache_wbuf_mem_adapter #(.WbufDataWidth(128), .MemDataWidth(64), .MaxOutstanding(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .send_meta_valid_i(a_mv), .send_meta_ready_o(a_mr), .send_addr_i(a_addr), .send_id_i(a_id), .send_uc_i(a_uc),
        .send_data_valid_i(a_dv), .send_data_ready_o(a_dr), .send_data_tag_i(a_tag), .send_data_i(a_data), .send_be_i(a_be),
        .mem_req_write_ready_i(a_qr), .mem_req_write_valid_o(a_qv), .mem_req_write_o(a_req),
        .mem_req_write_data_ready_i(a_wr), .mem_req_write_data_valid_o(a_wv), .mem_req_write_data_o(a_w),
        .mem_resp_write_ready_o(a_rr), .mem_resp_write_valid_i(a_rv), .mem_resp_write_i(a_resp),
        .ack_o(a_ack), .ack_id_o(a_aid), .ack_error_o(a_aerr), .outstanding_o(a_out), .idle_o(a_idle), .spurious_ack_o(a_spur));

    hpdcache_wbuf_mem_adapter #(.WbufDataWidth(64), .MemDataWidth(256), .hpdcache_mem_req_w_t(req_w256_t)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .send_meta_valid_i(1'b0), .send_meta_ready_o(b_mr), .send_addr_i(40'd0), .send_id_i(3'd0), .send_uc_i(1'b0),
        .send_data_valid_i(b_dv), .send_data_ready_o(b_dr), .send_data_tag_i(b_tag), .send_data_i(b_data), .send_be_i(b_be),
        .mem_req_write_ready_i(1'b1), .mem_req_write_valid_o(b_qv), .mem_req_write_o(b_req),
        .mem_req_write_data_ready_i(b_wr), .mem_req_write_data_valid_o(b_wv), .mem_req_write_data_o(b_w),
        .mem_resp_write_ready_o(b_rr), .mem_resp_write_valid_i(1'b0), .mem_resp_write_i('0),
        .ack_o(b_ack), .ack_id_o(b_aid), .ack_error_o(b_aerr), .outstanding_o(b_out), .idle_o(b_idle), .spurious_ack_o(b_spur));

    hpdcache_wbuf_mem_adapter #(.WbufDataWidth(256), .MemDataWidth(64), .MaxOutstanding(8)) dut_c (
        .clk_i(clk), .rst_i(rst),
        .send_meta_valid_i(c_mv), .send_meta_ready_o(c_mr), .send_addr_i(c_addr), .send_id_i(c_id), .send_uc_i(c_uc),
        .send_data_valid_i(c_dv), .send_data_ready_o(c_dr), .send_data_tag_i(c_tag), .send_data_i(c_data), .send_be_i(c_be),
        .mem_req_write_ready_i(c_qr), .mem_req_write_valid_o(c_qv), .mem_req_write_o(c_req),
        .mem_req_write_data_ready_i(c_wr), .mem_req_write_data_valid_o(c_wv), .mem_req_write_data_o(c_w),
        .mem_resp_write_ready_o(c_rr), .mem_resp_write_valid_i(c_rv), .mem_resp_write_i(c_resp),
        .ack_o(c_ack), .ack_id_o(c_aid), .ack_error_o(c_aerr), .outstanding_o(c_out), .idle_o(c_idle), .spurious_ack_o(c_spur));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_mv = 0; a_uc = 0; a_dv = 0; a_qr = 0; a_wr = 0; a_rv = 0;
        a_addr = '0; a_tag = '0; a_id = '0; a_data = '0; a_be = '0; a_resp = '0;
        b_dv = 0; b_wr = 0; b_tag = '0; b_data = '0; b_be = '0;
        c_mv = 0; c_uc = 0; c_dv = 0; c_qr = 0; c_wr = 0; c_rv = 0;
        c_addr = '0; c_tag = '0; c_id = '0; c_data = '0; c_be = '0; c_resp = '0;
    endtask

    vec_t  vecs[4];
    beat_t q[$];
    logic  pend[8];
    int    cnt;
    logic  exp_spur, gate, hit, exp_rdy;
    logic [2:0] rid;

    initial begin
        vecs[0] = '{40'd2, 64'h0123_4567_89ab_cdef, 8'hFF, 1'b1, 1'b1, 32'h00FF_0000, 1'b1, 1'b1};
        vecs[1] = '{40'd0, 64'hdead_beef_0000_1111, 8'h0F, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0};
        vecs[2] = '{40'd3, 64'h5555_aaaa_5555_aaaa, 8'h81, 1'b1, 1'b1, 32'h8100_0000, 1'b1, 1'b1};
        vecs[3] = '{40'd5, 64'hffff_0000_ffff_0000, 8'hFF, 1'b1, 1'b0, 32'h0000_FF00, 1'b0, 1'b1};

        // reset: handshakes blocked even with everything requesting
        clear_inputs();
        a_mv = 1; a_qr = 1; a_dv = 1; a_wr = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_meta_valid", a_qv, 0);
        chk("rst_meta_ready", a_mr, 0);
        chk("rst_data_valid", a_wv, 0);
        chk("rst_data_ready", a_dr, 0);
        clear_inputs();
        rst = 0;
        #1;
        chk("rst_outstanding", a_out, 0);
        chk("rst_idle", a_idle, 1);
        chk("rst_spurious", a_spur, 0);
        chk("rst_c_idle", c_idle, 1);

        // 1: DN=2 burst, back-to-back words
        a_wr = 1; a_dv = 1; a_be = 16'hFFFF;
        a_data = {{16{4'hA}}, {16{4'hB}}};
        #1;
        chk("t1_idle_ready", a_dr, 1);
        chk("t1_idle_novalid", a_wv, 0);
        step();
        a_data = {{16{4'hC}}, {16{4'hD}}};
        #1;
        chk("t1_b0_valid", a_wv, 1);
        chk("t1_b0_data", a_w.data, {16{4'hB}});
        chk("t1_b0_last", a_w.last, 0);
        chk("t1_b0_ready", a_dr, 0);
        step();
        chk("t1_b1_data", a_w.data, {16{4'hA}});
        chk("t1_b1_be", a_w.be, 8'hFF);
        chk("t1_b1_last", a_w.last, 1);
        chk("t1_b1_ready", a_dr, 1);
        step();
        a_dv = 0;
        #1;
        chk("t1_w1_b0_valid", a_wv, 1);
        chk("t1_w1_b0_data", a_w.data, {16{4'hD}});
        step();
        chk("t1_w1_b1_data", a_w.data, {16{4'hC}});
        chk("t1_w1_b1_last", a_w.last, 1);
        step();
        chk("t1_end_valid", a_wv, 0);
        chk("t1_end_idle", a_idle, 1);

        // 2: UP=4 lane steering, table driven
        chk("t2_size", b_req.size, 3);
        chk("t2_len", b_req.len, 0);
        for (int i = 0; i < 4; i++) begin
            b_tag = vecs[i].tag; b_data = vecs[i].data; b_be = vecs[i].be;
            b_wr = vecs[i].mready; b_dv = vecs[i].dvalid;
            #1;
            chk($sformatf("t2_be[%0d]", i), b_w.be, vecs[i].exp_be);
            chk($sformatf("t2_data[%0d]", i), b_w.data, {4{vecs[i].data}});
            chk($sformatf("t2_last[%0d]", i), b_w.last, 1);
            chk($sformatf("t2_valid[%0d]", i), b_wv, vecs[i].exp_valid);
            chk($sformatf("t2_ready[%0d]", i), b_dr, vecs[i].exp_ready);
            step();
        end
        b_dv = 0;

        // 3: MaxOutstanding=2 limit
        a_qr = 1; a_mv = 1; a_id = 0; a_addr = 40'h12_3456_7890; a_uc = 0;
        #1;
        chk("t3_m0_valid", a_qv, 1);
        chk("t3_m0_ready", a_mr, 1);
        chk("t3_addr", a_req.addr, 40'h12_3456_7890);
        chk("t3_id", a_req.id, 0);
        chk("t3_len", a_req.len, 1);
        chk("t3_size", a_req.size, 4);
        chk("t3_cmd", a_req.command, MEM_WRITE);
        chk("t3_cacheable", a_req.cacheable, 1);
        step();
        a_id = 1; a_uc = 1;
        #1;
        chk("t3_m1_valid", a_qv, 1);
        chk("t3_uncacheable", a_req.cacheable, 0);
        chk("t3_out1", a_out, 1);
        step();
        a_id = 2;
        #1;
        chk("t3_out2", a_out, 2);
        chk("t3_m2_stall_valid", a_qv, 0);
        chk("t3_m2_stall_ready", a_mr, 0);
        step();
        a_rv = 1; a_resp = '{RESP_OK, 8'd0};
        #1;
        chk("t3_ack", a_ack, 1);
        chk("t3_ack_id", a_aid, 0);
        chk("t3_still_stalled", a_qv, 0);
        step();
        a_rv = 0;
        #1;
        chk("t3_out_after_ack", a_out, 1);
        chk("t3_m2_go", a_qv, 1);
        step();
        a_mv = 0;
        #1;
        chk("t3_out_final", a_out, 2);
        a_rv = 1; a_resp = '{RESP_OK, 8'd1};
        step();
        a_resp = '{RESP_OK, 8'd2};
        step();
        a_rv = 0;
        #1;
        chk("t3_drained", a_out, 0);

        // 4: id reuse blocked; same-cycle ack and handshake
        c_qr = 1; c_mv = 1; c_id = 5;
        #1;
        chk("t4_m5_valid", c_qv, 1);
        step();
        chk("t4_reuse_stall", c_qv, 0);
        chk("t4_out1", c_out, 1);
        step();
        c_rv = 1; c_resp = '{RESP_OK, 8'd5};
        #1;
        chk("t4_stall_during_ack", c_qv, 0);
        step();
        c_rv = 0;
        #1;
        chk("t4_reuse_go", c_qv, 1);
        chk("t4_out0", c_out, 0);
        step();
        c_id = 3;
        #1;
        chk("t4_m3_valid", c_qv, 1);
        step();
        c_id = 4; c_rv = 1; c_resp = '{RESP_OK, 8'd3};
        #1;
        chk("t4_m4_valid", c_qv, 1);
        chk("t4_out2_before", c_out, 2);
        step();
        c_mv = 0; c_rv = 0;
        #1;
        chk("t4_out2_after", c_out, 2);
        c_rv = 1; c_resp = '{RESP_OK, 8'd5};
        step();
        c_resp = '{RESP_OK, 8'd4};
        step();
        c_rv = 0;
        #1;
        chk("t4_drained", c_out, 0);
        chk("t4_no_spurious", c_spur, 0);

        // 5: spurious ack and error flag
        c_rv = 1; c_resp = '{RESP_OK, 8'd6};
        #1;
        chk("t5_ack", c_ack, 1);
        chk("t5_ack_id", c_aid, 6);
        chk("t5_err_ok", c_aerr, 0);
        chk("t5_spur_not_yet", c_spur, 0);
        step();
        c_resp = '{RESP_SLVERR, 8'd6};
        #1;
        chk("t5_spur_pulse", c_spur, 1);
        chk("t5_out_zero", c_out, 0);
        chk("t5_err_slverr", c_aerr, 1);
        step();
        c_rv = 0;
        #1;
        chk("t5_spur_again", c_spur, 1);
        step();
        chk("t5_spur_clear", c_spur, 0);

        // 6: reset during beat 1 of a DN=4 burst
        c_mv = 1; c_id = 1;
        step();
        c_mv = 0; c_wr = 1; c_dv = 1; c_be = '1;
        c_data = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        step();
        c_dv = 0;
        #1;
        chk("t6_b0_data", c_w.data, {16{4'h1}});
        step();
        chk("t6_b1_data", c_w.data, {16{4'h2}});
        chk("t6_busy", c_idle, 0);
        rst = 1;
        #1;
        chk("t6_rst_gated", c_wv, 0);
        step();
        rst = 0;
        #1;
        chk("t6_valid_dropped", c_wv, 0);
        chk("t6_idle", c_idle, 1);
        chk("t6_out_zero", c_out, 0);

        // randomized run on instance c against a queue/array model
        clear_inputs();
        step();
        cnt = 0; exp_spur = 0; q.delete();
        for (int i = 0; i < 8; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            c_mv = ($urandom_range(0, 9) < 6);
            c_id = 3'($urandom);
            c_addr = {8'h00, $urandom};
            c_uc = 1'($urandom);
            c_qr = ($urandom_range(0, 3) != 0);
            c_rv = ($urandom_range(0, 9) < 3);
            c_resp = '{mem_error_e'($urandom_range(0, 3)), 8'($urandom)};
            c_dv = 1'($urandom);
            for (int k = 0; k < 8; k++) c_data[k*32 +: 32] = $urandom;
            c_be = $urandom;
            c_wr = ($urandom_range(0, 3) != 0);
            #1;
            gate = !pend[c_id] && (cnt < 8);
            exp_rdy = (q.size() == 0) || (q.size() == 1 && c_wr);
            chk("r_meta_valid", c_qv, c_mv && gate);
            chk("r_meta_ready", c_mr, c_qr && gate);
            chk("r_ack", c_ack, c_rv);
            chk("r_ack_id", c_aid, c_resp.id[2:0]);
            chk("r_ack_err", c_aerr, c_resp.error != RESP_OK);
            chk("r_spurious", c_spur, exp_spur);
            chk("r_outstanding", c_out, cnt);
            chk("r_idle", c_idle, (cnt == 0) && (q.size() == 0));
            chk("r_data_valid", c_wv, q.size() != 0);
            chk("r_data_ready", c_dr, exp_rdy);
            if (q.size() != 0) begin
                chk("r_beat_data", c_w.data, q[0].d);
                chk("r_beat_be", c_w.be, q[0].be);
                chk("r_beat_last", c_w.last, q[0].last);
            end
            rid = c_resp.id[2:0];
            exp_spur = c_rv && !pend[rid];
            hit = c_rv && pend[rid];
            if (q.size() != 0 && c_wr) void'(q.pop_front());
            if (c_dv && exp_rdy) begin
                for (int k = 0; k < 4; k++) q.push_back('{c_data[k*64 +: 64], c_be[k*8 +: 8], k == 3});
            end
            if (hit) begin
                pend[rid] = 0;
                cnt--;
            end
            if (c_mv && gate && c_qr) begin
                pend[c_id] = 1;
                cnt++;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
